// File: rtl/seven_seg_scroll_controller_if.sv
// Bundle of the message-write, control and display signals between lab logic
// (master) and the seven-segment scroll controller (slave).
interface seven_seg_scroll_controller_if #(
    parameter int w_digit = 8,
    parameter int max_len = 16,
    parameter int w_addr  = $clog2(max_len),
    parameter int w_len   = $clog2(max_len + 1)
);
    logic               wr_en;
    logic [w_addr-1:0]  wr_addr;
    logic [7:0]         wr_data;
    logic               len_we;
    logic [w_len-1:0]   len_data;
    logic               scroll_en;
    logic [7:0]         abcdefgh;
    logic [w_digit-1:0] digit;
    logic               frame_tick;

    modport master (
        output wr_en, wr_addr, wr_data, len_we, len_data, scroll_en,
        input  abcdefgh, digit, frame_tick
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len_we, len_data, scroll_en,
        output abcdefgh, digit, frame_tick
    );
endinterface

// File: rtl/seven_seg_scroll_controller.sv
// Time-multiplexed seven-segment driver with a message buffer that can be
// shown statically or rotated across the digits at a programmable rate.
module seven_seg_scroll_controller #(
    parameter int w_digit       = 8,
    parameter int max_len       = 16,
    parameter int scan_cycles   = 50000,
    parameter int scroll_frames = 250,
    parameter int w_addr        = $clog2(max_len),
    parameter int w_len         = $clog2(max_len + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    seven_seg_scroll_controller_if.slave  bus
);

    localparam int w_idx   = (w_digit > 1) ? $clog2(w_digit) : 1;
    localparam int w_scan  = (scan_cycles > 1) ? $clog2(scan_cycles) : 1;
    localparam int w_frame = (scroll_frames > 1) ? $clog2(scroll_frames) : 1;
    localparam int w_sum   = w_len + 1;

    localparam logic [w_scan-1:0]  scan_last  = w_scan'(scan_cycles - 1);
    localparam logic [w_frame-1:0] frame_last = w_frame'(scroll_frames - 1);
    localparam logic [w_idx-1:0]   idx_last   = w_idx'(w_digit - 1);
    localparam logic [w_len-1:0]   len_max    = w_len'(max_len);

    typedef enum logic [1:0] {
        IDLE,
        STATIC,
        SCROLL
    } state_t;

    state_t state;

    logic [7:0]         buf_mem [max_len];
    logic [w_len-1:0]   len_q,       len_d;
    logic [w_len-1:0]   offset_q,    offset_d;
    logic [w_scan-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [w_idx-1:0]   idx_q,       idx_d;
    logic [w_frame-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]         abcdefgh_q,  abcdefgh_d;
    logic [w_digit-1:0] digit_q,     digit_d;
    logic               frame_tick;
    logic [w_sum-1:0]   sum_mod;
    logic [7:0]         char_sel;

    // Operating mode follows the current length and scroll request directly.
    always_comb begin
        if (len_q == '0)
            state = IDLE;
        else if (bus.scroll_en)
            state = SCROLL;
        else
            state = STATIC;
    end

    // Pattern for the active position: rotated window in SCROLL, padded with blanks in STATIC.
    always_comb begin
        // NOTE: blocking assignments are right in combinational blocks; the loop
        // reuses sum_mod as a running value within a single evaluation.
        sum_mod = w_sum'(offset_q) + w_sum'(idx_q);
        for (int i = 0; i < w_digit; i++) begin
            if (sum_mod >= w_sum'(len_q))
                sum_mod = sum_mod - w_sum'(len_q);
        end
        if (state == SCROLL)
            char_sel = buf_mem[sum_mod[w_addr-1:0]];
        else if (w_len'(idx_q) < len_q)
            char_sel = buf_mem[w_addr'(idx_q)];
        else
            char_sel = 8'h00;
    end

    // Next-state logic for scan, frame and scroll counters plus the output registers.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        len_d       = len_q;
        offset_d    = offset_q;
        scan_cnt_d  = scan_cnt_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        abcdefgh_d  = 8'h00;
        digit_d     = '0;
        frame_tick  = 1'b0;

        if (state == IDLE) begin
            scan_cnt_d  = '0;
            idx_d       = '0;
            frame_cnt_d = '0;
        end else begin
            abcdefgh_d                = char_sel;
            digit_d[idx_last - idx_q] = 1'b1;

            if (scan_cnt_q == scan_last) begin
                scan_cnt_d = '0;
                idx_d      = (idx_q == idx_last) ? '0 : idx_q + 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end

            frame_tick = (idx_q == idx_last) && (scan_cnt_q == scan_last);

            if (frame_tick) begin
                if (frame_cnt_q == frame_last) begin
                    frame_cnt_d = '0;
                    if (state == SCROLL)
                        offset_d = (offset_q == len_q - 1'b1) ? '0 : offset_q + 1'b1;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
        end

        // A length load restarts everything and overrides a coincident scroll step.
        if (bus.len_we) begin
            len_d       = (bus.len_data > len_max) ? len_max : bus.len_data;
            offset_d    = '0;
            frame_cnt_d = '0;
            scan_cnt_d  = '0;
            idx_d       = '0;
        end
    end

    // State, output and message-buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffer is reset as well, because a reset must blank the
            // message; this rules out a plain RAM macro for buf_mem.
            for (int i = 0; i < max_len; i++)
                buf_mem[i] <= 8'h00;
            len_q       <= '0;
            offset_q    <= '0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            abcdefgh_q  <= 8'h00;
            digit_q     <= '0;
        end else begin
            if (bus.wr_en && (int'(bus.wr_addr) < max_len))
                buf_mem[bus.wr_addr] <= bus.wr_data;
            len_q       <= len_d;
            offset_q    <= offset_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            abcdefgh_q  <= abcdefgh_d;
            digit_q     <= digit_d;
        end
    end

    assign bus.abcdefgh   = abcdefgh_q;
    assign bus.digit      = digit_q;
    assign bus.frame_tick = frame_tick;

endmodule
